// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multicycle RV32 datapath. It decodes the 7-bit
//   opcode held in the instruction register and sequences the instruction
//   through fetch, decode, execute, memory and writeback. The FSM feeds ALUOp
//   into alu_control and drives the datapath enables and mux selects. Memory
//   accesses stall on mem_ready.
//
//   Only the state is registered. Every output is decoded combinationally from
//   the state, opcode, zero and mem_ready.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset; forces FETCH immediately
//   opcode[6:0]   instr[6:0] from the instruction register
//   zero          ALU zero flag, used as the branch-taken condition
//   mem_ready     memory completes the current access in this cycle
//   ALUOp[1:0]    00 add, 01 sub, 10 funct-decoded (to alu_control)
//   alu_src_a     00 PC, 01 oldPC, 10 rs1
//   alu_src_b     00 rs2, 01 imm, 10 constant 4
//   result_src    00 ALUOut, 01 mem data, 10 ALU result
//   adr_src       memory address select: 0 PC, 1 result
//   ir_write      latch the instruction and oldPC
//   pc_write      PC register enable
//   mem_write     memory write strobe
//   reg_write     register file write enable
//   illegal_instr one-cycle flag raised for an unknown opcode
//   state_o       current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_r;
    state_t next_state_s;

    // State register; reset takes effect asynchronously so pending writes drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= state_t'(RESET_STATE);
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state_s  = FETCH;
        ALUOp         = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;

        case (state_r)
            FETCH: begin
                // PC + 4 goes straight back to the PC on the cycle the fetch completes.
                adr_src    = 1'b0;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b10;
                ALUOp      = 2'b00;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                // oldPC + imm: the branch target is ready in ALUOut for BEQ.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                ALUOp     = 2'b00;
                case (opcode)
                    OP_LOAD:   next_state_s = MEMADR;
                    OP_STORE:  next_state_s = MEMADR;
                    OP_RTYPE:  next_state_s = EXECR;
                    OP_ITYPE:  next_state_s = EXECI;
                    OP_BRANCH: next_state_s = BEQ;
                    default:   next_state_s = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                ALUOp     = 2'b00;
                if (opcode == OP_LOAD) begin
                    next_state_s = MEMREAD;
                end else begin
                    next_state_s = MEMWRITE;
                end
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                result_src = 2'b00;
                if (mem_ready) begin
                    next_state_s = MEMWB;
                end else begin
                    next_state_s = MEMREAD;
                end
            end
            MEMWB: begin
                result_src   = 2'b01;
                reg_write    = 1'b1;
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                // The strobe is held until memory accepts the write.
                adr_src    = 1'b1;
                result_src = 2'b00;
                mem_write  = 1'b1;
                if (mem_ready) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEMWRITE;
                end
            end
            EXECR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b00;
                ALUOp        = 2'b10;
                next_state_s = ALUWB;
            end
            EXECI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                ALUOp        = 2'b10;
                next_state_s = ALUWB;
            end
            ALUWB: begin
                result_src   = 2'b00;
                reg_write    = 1'b1;
                next_state_s = FETCH;
            end
            BEQ: begin
                // rs1 - rs2 sets zero; the target computed in DECODE sits in ALUOut.
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b00;
                ALUOp        = 2'b01;
                result_src   = 2'b00;
                pc_write     = zero;
                next_state_s = FETCH;
            end
            TRAP: begin
                illegal_instr = 1'b1;
                next_state_s  = FETCH;
            end
            default: begin
                // Unused codes 11-15 recover to FETCH with every enable low.
                next_state_s = FETCH;
            end
        endcase
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       illegal_instr;
    logic [3:0] state_o;

    multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .ALUOp         (ALUOp),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: state, ALUOp, src_a, src_b, result_src, adr, ir, pc, mw, rw, ill
    logic [17:0] act;
    assign act = {state_o, ALUOp, alu_src_a, alu_src_b, result_src,
                  adr_src, ir_write, pc_write, mem_write, reg_write, illegal_instr};

    typedef struct {
        logic [17:0] vec;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [17:0] mk(input logic [3:0] s, input logic [1:0] op,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] r, input logic adr,
                                       input logic ir, input logic pc, input logic mw,
                                       input logic rw, input logic il);
        return {s, op, a, b, r, adr, ir, pc, mw, rw, il};
    endfunction

    // Expected output vectors, written out by hand from the state table.
    logic [17:0] V_FETCH1, V_FETCH0, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB;
    logic [17:0] V_MEMWRITE, V_EXECR, V_EXECI, V_ALUWB, V_BEQ1, V_BEQ0, V_TRAP;

    // Monitor: compares the DUT outputs against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s: got %b required %b (t=%0t)", e.name, act, e.vec, $time);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and post the expected outputs.
    task automatic step(input logic rst, input logic [6:0] op, input logic mr,
                        input logic z, input logic [17:0] v, input string nm);
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        sb_q.push_back('{vec: v, name: nm});
    endtask

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    initial begin
        V_FETCH1   = mk(4'd0,  2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        V_FETCH0   = mk(4'd0,  2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_DECODE   = mk(4'd1,  2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_MEMADR   = mk(4'd2,  2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_MEMREAD  = mk(4'd3,  2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_MEMWB    = mk(4'd4,  2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        V_MEMWRITE = mk(4'd5,  2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_EXECR    = mk(4'd6,  2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_EXECI    = mk(4'd7,  2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_ALUWB    = mk(4'd8,  2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        V_BEQ1     = mk(4'd9,  2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        V_BEQ0     = mk(4'd9,  2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_TRAP     = mk(4'd10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        rst_n     = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        zero      = 1'b0;

        // Reset state: FETCH decoding, ir/pc writes follow mem_ready.
        step(1'b0, OP_ST, 1'b0, 1'b0, V_FETCH0, "reset_fetch_mr0");
        step(1'b0, OP_ST, 1'b1, 1'b0, V_FETCH1, "reset_fetch_mr1");

        // Store reaching MEMWRITE, then reset while the write is pending.
        step(1'b1, OP_ST, 1'b1, 1'b0, V_FETCH1,   "st_fetch");
        step(1'b1, OP_ST, 1'b1, 1'b0, V_DECODE,   "st_decode");
        step(1'b1, OP_ST, 1'b1, 1'b0, V_MEMADR,   "st_memadr");
        step(1'b1, OP_ST, 1'b0, 1'b0, V_MEMWRITE, "st_memwrite_pending");
        step(1'b0, OP_ST, 1'b0, 1'b0, V_FETCH0,   "rst_mid_write_drop");
        step(1'b0, OP_ST, 1'b0, 1'b0, V_FETCH0,   "rst_mid_write_hold");
        step(1'b1, OP_R,  1'b1, 1'b0, V_FETCH1,   "rst_release_fetch");

        // R-type: 0,1,6,8,0
        step(1'b1, OP_R, 1'b1, 1'b0, V_DECODE, "r_decode");
        step(1'b1, OP_R, 1'b1, 1'b0, V_EXECR,  "r_execr");
        step(1'b1, OP_R, 1'b1, 1'b0, V_ALUWB,  "r_aluwb");

        // I-type: 0,1,7,8,0
        step(1'b1, OP_I, 1'b1, 1'b0, V_FETCH1, "i_fetch");
        step(1'b1, OP_I, 1'b1, 1'b0, V_DECODE, "i_decode");
        step(1'b1, OP_I, 1'b1, 1'b0, V_EXECI,  "i_execi");
        step(1'b1, OP_I, 1'b1, 1'b0, V_ALUWB,  "i_aluwb");

        // Load with fetch stall, then two MEMREAD stall cycles: 0,0,1,2,3,3,3,4,0
        step(1'b1, OP_LD, 1'b0, 1'b0, V_FETCH0,  "ld_fetch_stall");
        step(1'b1, OP_LD, 1'b1, 1'b0, V_FETCH1,  "ld_fetch");
        step(1'b1, OP_LD, 1'b1, 1'b0, V_DECODE,  "ld_decode");
        step(1'b1, OP_LD, 1'b1, 1'b0, V_MEMADR,  "ld_memadr");
        step(1'b1, OP_LD, 1'b0, 1'b0, V_MEMREAD, "ld_memread_w1");
        step(1'b1, OP_LD, 1'b0, 1'b0, V_MEMREAD, "ld_memread_w2");
        step(1'b1, OP_LD, 1'b1, 1'b0, V_MEMREAD, "ld_memread_done");
        step(1'b1, OP_LD, 1'b1, 1'b0, V_MEMWB,   "ld_memwb");

        // Store with one MEMWRITE stall: mem_write for 2 cycles
        step(1'b1, OP_ST, 1'b1, 1'b0, V_FETCH1,   "st2_fetch");
        step(1'b1, OP_ST, 1'b1, 1'b0, V_DECODE,   "st2_decode");
        step(1'b1, OP_ST, 1'b1, 1'b0, V_MEMADR,   "st2_memadr");
        step(1'b1, OP_ST, 1'b0, 1'b0, V_MEMWRITE, "st2_memwrite_w");
        step(1'b1, OP_ST, 1'b1, 1'b0, V_MEMWRITE, "st2_memwrite_done");

        // Branch taken
        step(1'b1, OP_BR, 1'b1, 1'b1, V_FETCH1, "beq_t_fetch");
        step(1'b1, OP_BR, 1'b1, 1'b1, V_DECODE, "beq_t_decode");
        step(1'b1, OP_BR, 1'b1, 1'b1, V_BEQ1,   "beq_taken");

        // Branch not taken
        step(1'b1, OP_BR, 1'b1, 1'b0, V_FETCH1, "beq_n_fetch");
        step(1'b1, OP_BR, 1'b1, 1'b0, V_DECODE, "beq_n_decode");
        step(1'b1, OP_BR, 1'b1, 1'b0, V_BEQ0,   "beq_not_taken");

        // Illegal opcode: one TRAP cycle, then FETCH
        step(1'b1, OP_BAD, 1'b1, 1'b0, V_FETCH1, "trap_fetch");
        step(1'b1, OP_BAD, 1'b1, 1'b0, V_DECODE, "trap_decode");
        step(1'b1, OP_BAD, 1'b1, 1'b0, V_TRAP,   "trap");
        step(1'b1, OP_BAD, 1'b0, 1'b0, V_FETCH0, "trap_back_fetch");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32 datapath; directly upstream of alu_control.
- Decodes the 7-bit opcode of the latched instruction and sequences fetch/decode/execute/memory/writeback.
- Drives ALUOp (00 add, 01 sub, 10 funct-decoded) into alu_control, plus datapath enables and mux selects.
- Stalls on a memory-ready handshake.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); all other state codes are fixed, listed below.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instr[6:0] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- ALUOp  output  2  to alu_control
- alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1
- alu_src_b  output  2  00 rs2, 01 imm, 10 constant 4
- result_src  output  2  00 ALUOut, 01 mem data, 10 ALU result
- adr_src  output  1  0 PC, 1 result
- ir_write  output  1  latch instruction and oldPC
- pc_write  output  1  PC register enable
- mem_write  output  1  memory write strobe
- reg_write  output  1  register file write enable
- illegal_instr  output  1  one-cycle flag for an unknown opcode
- state_o  output  4  current state, for debug

Behaviour:
- Only `state` is registered. On rst_n low, state is forced asynchronously to FETCH. All outputs are combinational from state, opcode, zero and mem_ready.
- While in reset, outputs equal FETCH decoding: alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10, adr_src=0, mem_write=0, reg_write=0, illegal_instr=0. ir_write and pc_write follow mem_ready.
- Any signal not listed for a state is 0 in that state.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, TRAP=10. Codes 11-15 go to FETCH on the next edge with all enables 0.
- FETCH: adr_src=0; alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10; ir_write=pc_write=mem_ready. Stay while !mem_ready, otherwise go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00 (computes branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - anything else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00. Next is MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Stay while !mem_ready, otherwise MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held every cycle until mem_ready. Goes to FETCH on the mem_ready cycle.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00; pc_write=zero. Then FETCH unconditionally.
- TRAP: illegal_instr=1 for exactly one cycle, no writes, then FETCH.
- Instruction latency with mem_ready=1 throughout:
  - R-type/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - illegal: 3 cycles
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Opcode changes are only sampled in DECODE and MEMADR; the IR is stable after FETCH.
- Reset asserted mid-instruction returns to FETCH immediately, with no completion of a pending write. mem_write and reg_write drop in the same cycle rst_n falls.
- pc_write is never asserted outside FETCH and BEQ. reg_write and mem_write are never asserted in the same cycle.

Test Plan:
- Reset mid-MEMWRITE (rst_n low for 2 cycles, mem_ready=0) -> mem_write drops with rst_n, state_o=0. After release with mem_ready=1: ir_write=1, pc_write=1, ALUOp=00, alu_src_b=10.
- R-type opcode 0110011, mem_ready=1 -> state_o sequence 0,1,6,8,0. ALUOp=10 and alu_src_b=00 in EXECR; reg_write=1 only in ALUWB. Repeat with 0010011: 0,1,7,8,0 with alu_src_b=01.
- Load 0000011, mem_ready low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0. adr_src=1 in MEMREAD; result_src=01 and reg_write=1 in MEMWB.
- Store 0100011, mem_ready low for 1 cycle in MEMWRITE -> mem_write=1 for 2 consecutive cycles, reg_write=0 throughout, then state_o=0.
- Branch 1100011 -> ALUOp=01 in BEQ. With zero=1, pc_write=1; with zero=0, pc_write=0. Both return to FETCH after 3 cycles.
- Opcode 1111111 -> DECODE goes to TRAP, illegal_instr=1 for exactly 1 cycle, no reg_write/mem_write/pc_write asserted, then FETCH.
